sig_gen: RTL and testbench
==========================

# sig_gen

Programmable square-wave generator that produces a test signal at a frequency entered as four BCD digits, with a ×10 range mode. It is the source end of the frequency-measurement path: its `sigout` drives the meter's signal input, and its `range_out` matches the meter's high-frequency mode. Frequency synthesis is exact on average, using a fractional (Bresenham-style) accumulator clocked by `sysclk`.

## Interface
- `CLK_HZ`, default 100_000_000: `sysclk` frequency in Hz. Must satisfy 2·99990 < `CLK_HZ` < 2^28.
- `sysclk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle request to apply a new setting.
- `d_th`, `d_hun`, `d_ten`, `d_one`  in  4 each  BCD digits, sampled with `load`.
- `range_x10`  in  1  sampled with `load`; 1 multiplies the entered value by 10.
- `enable`  in  1  level; 0 holds the output idle.
- `sigout`  out  1  generated square wave.
- `busy`  out  1  conversion in progress; `load` is ignored while high.
- `err`  out  1  last `load` carried a non-BCD digit.
- `freq_bin`  out  17  currently applied frequency in Hz (0..99990).
- `range_out`  out  1  range of the applied setting.

## Operation
- FSM states:
  - IDLE: wait for `load`.
  - CONV: 4 cycles, one digit per cycle, most-significant digit first: `val <= val*10 + digit`, with ×10 computed as (v<<3)+(v<<1).
  - APPLY: 1 cycle.
- `load` in IDLE:
  - If any digit is > 9: set `err`=1, stay in IDLE, leave `busy`=0, keep the applied frequency unchanged.
  - Otherwise: capture the digits and range, clear `err`, clear `val`, go to CONV.
- `load` in CONV or APPLY is ignored. It is not queued and does not change `err`.
- APPLY updates the live registers:
  - `freq_bin <= range ? val*10 : val`
  - `range_out <= range`
  - `inc <= 2*freq` (18 bits)
  - then return to IDLE.
- Accumulator `acc` is 28 bits, with invariant `acc < CLK_HZ`. Each cycle with `enable`=1 and `inc`≠0:
  - If `acc + inc >= CLK_HZ`: `acc <= acc + inc - CLK_HZ` and toggle `sigout`.
  - Otherwise: `acc <= acc + inc`.
- Frequency changes are phase-continuous: APPLY does not clear `acc` or `sigout`. The new `inc` is used from the cycle after APPLY.
- When `enable`=0 or `inc`=0: `acc` is cleared and `sigout` is forced to 0 on the next edge.
- Toggle spacing is CLK_HZ/(2f) cycles on average. When that value is an integer, every interval equals it exactly.

## Timing
- Reset values: `sigout`=0, `busy`=0, `err`=0, `freq_bin`=0, `range_out`=0, `acc`=0, `inc`=0, state IDLE.
- `load` is sampled at edge k. `busy` is 1 after edges k through k+4 (5 cycles). Edge k+5 is APPLY: `freq_bin` and `inc` are updated and `busy` returns to 0.
- A new `load` is accepted at edge k+6 at the earliest, i.e. when asserted in the cycle `busy` reads 0.
- `err` rises one cycle after a rejected `load` and stays high until the next accepted `load`.
- First toggle at the new frequency: at most ceil(CLK_HZ/(2f)) cycles after APPLY.
- `reset` has priority in every state. Asserting it mid-conversion aborts the conversion and restores all reset values.
- `load` and `enable` falling in the same cycle: the load is processed normally, and `sigout` goes to 0 independently of the FSM.

## Structure
- Package `sig_gen_pkg` holds:
  - the state enum (IDLE, CONV, APPLY)
  - width constants: BCD 4, FREQ 17, INC 18, ACC 28
  - `MAX_FREQ = 99990`
- Sub-module `frac_toggle`:
  - ports: `sysclk`, `reset`, `enable`, `inc[17:0]`, `sigout`
  - parameter: `CLK_HZ`
  - contains the accumulator and output flip-flop.
- The top level contains the BCD-to-binary FSM and the applied-setting registers.

## Test plan
- Reset → all outputs 0. With `enable`=1 and no load, `sigout` stays 0 for 10000 cycles.
- `CLK_HZ`=1_000_000, load 1,0,0,0 with range 0 → `busy` high for exactly 5 cycles, `freq_bin`=1000, `sigout` toggles every 500 cycles, 50% duty.
- Load 1,2,3,4 with range 1 → `freq_bin`=12340, `range_out`=1. Over 1_000_000 cycles, count 12340 ±1 rising edges.
- Load with `d_ten`=4'hA → `err`=1, `busy` stays 0, `freq_bin` and `sigout` period unchanged. The next valid load clears `err`.
- Load pulses at offsets +1..+4 during a conversion are ignored: the result equals the first load's value. Load 0,0,0,0 → `sigout` goes low and stays low.
- Reset asserted at edge k+2 of a conversion → all reset values at the next edge. No APPLY occurs, and `freq_bin` stays 0.

Source files
------------

// File: rtl/sig_gen_pkg.sv
// sig_gen_pkg: shared types and constants for the sig_gen square-wave source.
// Holds the conversion FSM state type, datapath widths, the largest
// reachable frequency, and small helpers for the BCD-to-binary datapath.
package sig_gen_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam int unsigned FREQ_W   = 17;
    localparam int unsigned INC_W    = 18;
    localparam int unsigned ACC_W    = 28;
    localparam int unsigned MAX_FREQ = 99990;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        APPLY
    } state_t;

    // Multiply by ten with two shifts and an add.
    function automatic logic [FREQ_W-1:0] times10(input logic [FREQ_W-1:0] v);
        return (v << 3) + (v << 1);
    endfunction

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/sig_gen_if.sv
// sig_gen_if: setting/status bus of the signal generator.
//   load, d_th, d_hun, d_ten, d_one, range_x10 : new setting request (master -> slave)
//   busy, err, freq_bin, range_out             : conversion status and applied setting
interface sig_gen_if;
    import sig_gen_pkg::*;

    logic              load;
    logic [BCD_W-1:0]  d_th;
    logic [BCD_W-1:0]  d_hun;
    logic [BCD_W-1:0]  d_ten;
    logic [BCD_W-1:0]  d_one;
    logic              range_x10;
    logic              busy;
    logic              err;
    logic [FREQ_W-1:0] freq_bin;
    logic              range_out;

    modport master (
        output load, d_th, d_hun, d_ten, d_one, range_x10,
        input  busy, err, freq_bin, range_out
    );

    modport slave (
        input  load, d_th, d_hun, d_ten, d_one, range_x10,
        output busy, err, freq_bin, range_out
    );

endinterface

// File: rtl/sig_gen_frac_toggle.sv
// frac_toggle: fractional accumulator that toggles sigout at an exact
// average rate of inc toggles per CLK_HZ cycles (inc = 2*f gives f Hz).
//   sysclk  : clock
//   reset   : synchronous active-high reset
//   enable  : 0 clears the accumulator and holds sigout low
//   inc     : per-cycle phase increment; 0 also idles the output
//   sigout  : generated square wave
module frac_toggle
    import sig_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             enable,
    input  logic [INC_W-1:0] inc,
    output logic             sigout
);

    localparam logic [ACC_W:0] LIMIT = (ACC_W + 1)'(CLK_HZ);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             sig_q;
    logic             sig_d;
    logic [ACC_W:0]   sum;

    // One extra bit so acc + inc cannot overflow before the compare.
    assign sum = {1'b0, acc_q} + (ACC_W + 1)'(inc);

    always_comb begin
        acc_d = '0;
        sig_d = 1'b0;
        if (enable && (inc != '0)) begin
            if (sum >= LIMIT) begin
                acc_d = ACC_W'(sum - LIMIT);
                sig_d = ~sig_q;
            end else begin
                acc_d = sum[ACC_W-1:0];
                sig_d = sig_q;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            acc_q <= '0;
            sig_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sig_q <= sig_d;
        end
    end

    assign sigout = sig_q;

endmodule

// File: rtl/sig_gen.sv
// sig_gen: programmable square-wave generator. Four BCD digits (optionally
// x10) are converted to binary over four cycles, then applied as the
// increment of a fractional toggle accumulator.
//   sysclk : clock
//   reset  : synchronous active-high reset
//   enable : level; 0 idles sigout low
//   sigout : generated square wave
//   bus    : setting request and status (see sig_gen_if)
module sig_gen
    import sig_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic     sysclk,
    input  logic     reset,
    input  logic     enable,
    output logic     sigout,
    sig_gen_if.slave bus
);

    state_t                      state_q;
    state_t                      state_d;
    logic [3:0][BCD_W-1:0]       digits_q;
    logic [1:0]                  cnt_q;
    logic [FREQ_W-1:0]           val_q;
    logic                        range_q;
    logic                        err_q;
    logic [FREQ_W-1:0]           freq_q;
    logic                        range_out_q;
    logic [INC_W-1:0]            inc_q;

    logic                        bad_digit;
    logic                        accept;
    logic                        reject;
    logic                        step;
    logic                        apply;
    logic [FREQ_W-1:0]           val_next;
    logic [FREQ_W-1:0]           freq_new;

    assign bad_digit = !is_bcd(bus.d_th) || !is_bcd(bus.d_hun) ||
                       !is_bcd(bus.d_ten) || !is_bcd(bus.d_one);

    // digits_q[0] holds the thousands digit so cnt_q walks MSD first.
    assign val_next = times10(val_q) + FREQ_W'(digits_q[cnt_q]);
    assign freq_new = range_q ? times10(val_q) : val_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        step    = 1'b0;
        apply   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    if (bad_digit) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                step = 1'b1;
                if (cnt_q == 2'd3) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                apply   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= IDLE;
            digits_q    <= '0;
            cnt_q       <= '0;
            val_q       <= '0;
            range_q     <= 1'b0;
            err_q       <= 1'b0;
            freq_q      <= '0;
            range_out_q <= 1'b0;
            inc_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                digits_q <= {bus.d_one, bus.d_ten, bus.d_hun, bus.d_th};
                range_q  <= bus.range_x10;
                err_q    <= 1'b0;
                val_q    <= '0;
                cnt_q    <= '0;
            end
            if (reject) begin
                err_q <= 1'b1;
            end
            if (step) begin
                val_q <= val_next;
                cnt_q <= cnt_q + 2'd1;
            end
            if (apply) begin
                freq_q      <= freq_new;
                range_out_q <= range_q;
                inc_q       <= {freq_new, 1'b0};
            end
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;
    assign bus.freq_bin  = freq_q;
    assign bus.range_out = range_out_q;

    frac_toggle #(
        .CLK_HZ(CLK_HZ)
    ) u_toggle (
        .sysclk(sysclk),
        .reset (reset),
        .enable(enable),
        .inc   (inc_q),
        .sigout(sigout)
    );

endmodule

// File: tb/tb_sig_gen.sv
// tb_sig_gen: self-checking bench for sig_gen at CLK_HZ = 1 MHz.
// A vector table drives loads and checks busy width, err, freq_bin and
// range_out; hand-written sequences cover toggle spacing, edge counts,
// ignored loads, enable drop, zero frequency and reset mid-conversion.
module tb_sig_gen;

    logic sysclk;
    logic reset;
    logic enable;
    logic sigout;
    int   cyc;
    int   pass_cnt;
    int   total_cnt;

    sig_gen_if bus ();

    sig_gen #(
        .CLK_HZ(1_000_000)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .enable(enable),
        .sigout(sigout),
        .bus   (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  th;
        logic [3:0]  hun;
        logic [3:0]  ten;
        logic [3:0]  one;
        logic        rng;
        logic        exp_err;
        int          exp_busy;
        logic [16:0] exp_freq;
        logic        exp_range;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
        total_cnt++;
        if (act >= lo && act <= hi) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d, input logic r);
        bus.d_th      = a;
        bus.d_hun     = b;
        bus.d_ten     = c;
        bus.d_one     = d;
        bus.range_x10 = r;
        bus.load      = 1'b1;
        tick();
        bus.load      = 1'b0;
    endtask

    // Counts cycles busy reads high, starting at the current sample.
    task automatic busy_len(output int n);
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_toggle(input int bound, output int at, output bit ok);
        logic prev;
        prev = sigout;
        ok   = 1'b0;
        at   = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (sigout !== prev) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_intervals(input string name, input int exp, input int n);
        int t0, t1;
        bit ok;
        wait_toggle(2 * exp + 4, t0, ok);
        chk({name, "_sync"}, ok, 1);
        for (int i = 0; i < n; i++) begin
            wait_toggle(exp + 4, t1, ok);
            chk(name, t1 - t0, exp);
            t0 = t1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, hi_cnt, rises, hb;
        bit ok;
        logic prev;

        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        bus.load  = 1'b0;
        bus.d_th  = '0;
        bus.d_hun = '0;
        bus.d_ten = '0;
        bus.d_one = '0;
        bus.range_x10 = 1'b0;

        vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 5, 17'd12340, 1'b1};
        vecs[1] = '{4'd5, 4'd0, 4'hA, 4'd0, 1'b0, 1'b1, 0, 17'd12340, 1'b1};
        vecs[2] = '{4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 1'b0, 5, 17'd99990, 1'b1};
        vecs[3] = '{4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 1'b0, 5, 17'd42,    1'b0};
        vecs[4] = '{4'hF, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 0, 17'd42,    1'b0};
        vecs[5] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 5, 17'd0,     1'b1};
        vecs[6] = '{4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 5, 17'd1000,  1'b0};

        repeat (3) tick();
        chk("rst_sigout", sigout, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_freq_bin", bus.freq_bin, 0);
        chk("rst_range_out", bus.range_out, 0);

        reset  = 1'b0;
        enable = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (sigout !== 1'b0) hi_cnt++;
        end
        chk("idle_no_output", hi_cnt, 0);

        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].th, vecs[i].hun, vecs[i].ten, vecs[i].one, vecs[i].rng);
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d_err", i), bus.err, 1);
                chk($sformatf("v%0d_busy", i), bus.busy, 0);
                tick();
            end else begin
                busy_len(n);
                chk($sformatf("v%0d_busy_len", i), n, vecs[i].exp_busy);
                chk($sformatf("v%0d_err", i), bus.err, 0);
            end
            chk($sformatf("v%0d_freq_bin", i), bus.freq_bin, vecs[i].exp_freq);
            chk($sformatf("v%0d_range_out", i), bus.range_out, vecs[i].exp_range);
        end

        // 1000 Hz just applied from an idle accumulator.
        wait_toggle(500, t, ok);
        chk("first_toggle_1k", ok, 1);
        check_intervals("interval_1k", 500, 4);

        // Rejected load leaves the running setting untouched.
        do_load(4'd1, 4'd2, 4'hA, 4'd4, 1'b0);
        chk("bad_err", bus.err, 1);
        chk("bad_busy", bus.busy, 0);
        tick();
        chk("bad_freq_bin", bus.freq_bin, 1000);
        check_intervals("interval_after_bad", 500, 2);

        // Loads during a conversion are dropped.
        bus.d_th = 4'd2; bus.d_hun = 4'd0; bus.d_ten = 4'd0; bus.d_one = 4'd0;
        bus.range_x10 = 1'b0;
        bus.load = 1'b1;
        tick();
        hb = bus.busy;
        bus.d_th = 4'd7; bus.d_hun = 4'd7; bus.d_ten = 4'd7; bus.d_one = 4'd7;
        bus.range_x10 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            hb += bus.busy;
        end
        bus.load = 1'b0;
        tick();
        chk("ign_busy_cycles", hb, 5);
        chk("ign_busy_done", bus.busy, 0);
        chk("ign_freq_bin", bus.freq_bin, 2000);
        chk("ign_range_out", bus.range_out, 0);
        chk("ign_err", bus.err, 0);
        check_intervals("interval_2k", 250, 2);

        // Edge count at 12340 Hz over 20000 cycles: 246.8 expected.
        do_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        busy_len(n);
        chk("f12340_freq_bin", bus.freq_bin, 12340);
        chk("f12340_range_out", bus.range_out, 1);
        rises = 0;
        prev  = sigout;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (sigout === 1'b1 && prev === 1'b0) rises++;
            prev = sigout;
        end
        chk_range("f12340_rises", rises, 246, 248);

        // Load and enable drop in the same cycle.
        bus.d_th = 4'd0; bus.d_hun = 4'd5; bus.d_ten = 4'd0; bus.d_one = 4'd0;
        bus.range_x10 = 1'b0;
        bus.load = 1'b1;
        enable   = 1'b0;
        tick();
        bus.load = 1'b0;
        chk("endrop_sigout", sigout, 0);
        busy_len(n);
        chk("endrop_busy_len", n, 5);
        chk("endrop_freq_bin", bus.freq_bin, 500);
        repeat (20) tick();
        chk("endrop_sigout_held", sigout, 0);
        enable = 1'b1;
        wait_toggle(1000, t, ok);
        chk("reenable_toggle", ok, 1);

        // Zero frequency idles the output.
        do_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        busy_len(n);
        chk("zero_freq_bin", bus.freq_bin, 0);
        tick();
        hi_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (sigout !== 1'b0) hi_cnt++;
            tick();
        end
        chk("zero_sigout_low", hi_cnt, 0);

        // Reset at edge k+2 of a conversion.
        do_load(4'd0, 4'd1, 4'd0, 4'd0, 1'b1);
        busy_len(n);
        chk("pre_rst_freq_bin", bus.freq_bin, 1000);
        chk("pre_rst_range_out", bus.range_out, 1);
        do_load(4'd3, 4'd0, 4'd0, 4'd0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_err", bus.err, 0);
        chk("midrst_freq_bin", bus.freq_bin, 0);
        chk("midrst_range_out", bus.range_out, 0);
        chk("midrst_sigout", sigout, 0);
        reset = 1'b0;
        repeat (10) tick();
        chk("postrst_freq_bin", bus.freq_bin, 0);
        chk("postrst_busy", bus.busy, 0);
        chk("postrst_sigout", sigout, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
